param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 26 ++
 rtl/param_sync_fifo.sv | 102 ++++++++++
 tb/tb_param_sync_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Default geometry and pointer-width helper.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one asynchronous read port.
// No reset; contents are discarded logically by the controller.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AW         = ptr_w(DEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO controller.
// Pointers, occupancy, flags, error pulses and read register.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  if (DEPTH < 4 || DEPTH > 1024 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
    $error("param_sync_fifo: AE_THRESH must be below AF_THRESH");
  end

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_acc;
  logic                  rd_acc;

  assign fifo_full    = (count == FULL_C);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en && !fifo_full;
  assign rd_acc = rd_en && !fifo_empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && fifo_full;
      underflow <= rd_en && fifo_empty;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= rdata;
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo, registered and FWFT modes.
// A queue model tracks contents, occupancy and flags per cycle.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic       rst1;
  logic       wr1;
  logic       rd1;
  logic [7:0] din1;
  logic [7:0] dout1;
  logic       full1;
  logic       empty1;
  logic       af1;
  logic       ae1;
  logic [4:0] count1;
  logic       ovf1;
  logic       udf1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout;

  always #5 clk = ~clk;

  param_sync_fifo #(.FWFT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  param_sync_fifo #(.FWFT(1)) dut_fwft (
    .clk          (clk),
    .rst          (rst1),
    .wr_en        (wr1),
    .data_in      (din1),
    .rd_en        (rd1),
    .data_out     (dout1),
    .fifo_full    (full1),
    .fifo_empty   (empty1),
    .almost_full  (af1),
    .almost_empty (ae1),
    .count        (count1),
    .overflow     (ovf1),
    .underflow    (udf1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit w, input bit r,
                     input logic [7:0] d);
    int  n;
    bit  wa;
    bit  ra;
    n  = q.size();
    wa = w && (n < 16);
    ra = r && (n > 0);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    n = q.size();
    chk("count", 32'(count), n);
    chk("dout", 32'(data_out), 32'(exp_dout));
    chk("full", 32'(fifo_full), 32'(n == 16));
    chk("empty", 32'(fifo_empty), 32'(n == 0));
    chk("afull", 32'(almost_full), 32'(n >= 14));
    chk("aempty", 32'(almost_empty), 32'(n <= 2));
    chk("ovf", 32'(overflow), 32'(w && !wa));
    chk("udf", 32'(underflow), 32'(r && !ra));
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 8'h77;
    rst1 = 1'b1;
    wr1 = 1'b0;
    rd1 = 1'b0;
    din1 = 8'h00;
    exp_dout = 8'h00;

    // requests during reset must be ignored
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_cnt", 32'(count), 0);
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rel_empty", 32'(fifo_empty), 1);
    chk("rel_ae", 32'(almost_empty), 1);
    chk("rel_full", 32'(fifo_full), 0);
    chk("rel_af", 32'(almost_full), 0);
    chk("rel_cnt", 32'(count), 0);
    chk("rel_dout", 32'(data_out), 0);

    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_cnt", 32'(count), 16);
    cyc(1'b1, 1'b0, 8'hEE);
    chk("extra_ovf", 32'(overflow), 1);
    chk("extra_cnt", 32'(count), 16);
    cyc(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(overflow), 0);

    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(data_out), i);
    end
    cyc(1'b0, 1'b1, 8'h00);
    chk("uf_pulse", 32'(underflow), 1);
    chk("uf_hold", 32'(data_out), 32'h10);
    cyc(1'b0, 1'b0, 8'h00);
    chk("uf_clear", 32'(underflow), 0);

    // empty: simultaneous write wins, no bypass
    cyc(1'b1, 1'b1, 8'h99);
    chk("sim_empty_cnt", 32'(count), 1);
    chk("sim_empty_udf", 32'(underflow), 1);
    chk("sim_empty_dout", 32'(data_out), 32'h10);
    cyc(1'b0, 1'b1, 8'h00);
    chk("sim_empty_rd", 32'(data_out), 32'h99);

    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    // full: simultaneous read wins
    cyc(1'b1, 1'b1, 8'hFF);
    chk("sim_full_cnt", 32'(count), 15);
    chk("sim_full_ovf", 32'(overflow), 1);
    chk("sim_full_dout", 32'(data_out), 32'h21);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("at8_cnt", 32'(count), 8);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b1, 8'(8'h40 + k));
      chk("steady8", 32'(count), 8);
    end
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);

    // 40 writes with 3-in-4 reads wrap the pointers twice
    for (int i = 0; i < 40; i++)
      cyc(1'b1, (i % 4) != 0, 8'(8'h50 + i));
    chk("wrap_cnt", 32'(count), 10);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
    chk("wrap_full", 32'(fifo_full), 1);
    while (q.size() > 0) cyc(1'b0, 1'b1, 8'h00);

    // FWFT instance
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    wr1 = 1'b1;
    din1 = 8'hA5;
    @(posedge clk);
    #1;
    wr1 = 1'b0;
    chk("fw_empty", 32'(empty1), 0);
    chk("fw_dout", 32'(dout1), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      wr1 = 1'b1;
      din1 = 8'(8'hB0 + i);
      @(posedge clk);
      #1;
    end
    wr1 = 1'b0;
    chk("fw_cnt5", 32'(count1), 5);
    chk("fw_head", 32'(dout1), 32'hA5);
    rd1 = 1'b1;
    @(posedge clk);
    #1;
    rd1 = 1'b0;
    chk("fw_adv", 32'(dout1), 32'hB0);
    chk("fw_cnt4", 32'(count1), 4);
    wr1 = 1'b1;
    din1 = 8'hC0;
    @(posedge clk);
    #1;
    wr1 = 1'b0;
    chk("fw_cnt5b", 32'(count1), 5);
    #1;
    rst1 = 1'b1;
    #1;
    chk("fw_async_cnt", 32'(count1), 0);
    chk("fw_async_emp", 32'(empty1), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
